// File: rtl/motor_pkg.sv
// Shared motor-control types and default timing constants.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } motor_state_t;

  localparam int DEF_PERIOD   = 100;
  localparam int DEF_DEADTIME = 4;

endpackage

// File: rtl/motor_pwm.sv
// Single-channel motor PWM with shadowed duty/direction commands applied at
// period boundaries and a forced-low dead time on direction reversal.
module motor_pwm
  import motor_pkg::*;
#(
  parameter int PERIOD   = DEF_PERIOD,
  parameter int DEADTIME = DEF_DEADTIME
) (
  input  logic                          clk_in,
  input  logic                          reset_n_in,
  input  logic                          tick_in,
  input  logic                          enable_in,
  input  logic [$clog2(PERIOD+1)-1:0]   duty_in,
  input  logic                          dir_in,
  input  logic                          cmd_valid_in,
  output logic                          cmd_ready_out,
  output logic                          pwm_out,
  output logic                          dir_out,
  output logic                          period_start_out
);

  localparam int DW = $clog2(PERIOD + 1);
  localparam logic [DW-1:0] DUTY_MAX  = DW'(PERIOD);
  localparam logic [DW-1:0] CNT_LAST  = DW'(PERIOD - 1);
  localparam logic [7:0]    DEAD_LAST = 8'(DEADTIME - 1);

  motor_state_t   state_reg;
  logic [DW-1:0]  cnt_reg;
  logic [DW-1:0]  duty_active_reg;
  logic [DW-1:0]  shadow_duty_reg;
  logic           shadow_dir_reg;
  logic           pending_reg;
  logic [7:0]     dead_cnt_reg;
  logic [DW-1:0]  duty_clamped;

  assign duty_clamped  = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
  assign cmd_ready_out = !pending_reg;

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      duty_active_reg  <= '0;
      shadow_duty_reg  <= '0;
      shadow_dir_reg   <= 1'b0;
      pending_reg      <= 1'b0;
      dead_cnt_reg     <= '0;
      pwm_out          <= 1'b0;
      dir_out          <= 1'b0;
      period_start_out <= 1'b0;
    end else begin
      period_start_out <= 1'b0;

      // Capture and apply never collide: capture needs pending clear, apply needs it set.
      if (cmd_valid_in && !pending_reg) begin
        shadow_duty_reg <= duty_clamped;
        shadow_dir_reg  <= dir_in;
        pending_reg     <= 1'b1;
      end

      if (!enable_in) begin
        state_reg    <= IDLE;
        cnt_reg      <= '0;
        dead_cnt_reg <= '0;
        pwm_out      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (pending_reg) begin
              dir_out         <= shadow_dir_reg;
              duty_active_reg <= shadow_duty_reg;
              pending_reg     <= 1'b0;
            end
            state_reg        <= RUN;
            cnt_reg          <= '0;
            pwm_out          <= 1'b0;
            period_start_out <= 1'b1;
          end

          RUN: begin
            pwm_out <= (cnt_reg < duty_active_reg);
            if (tick_in) begin
              if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
                if (pending_reg && (shadow_dir_reg != dir_out)) begin
                  state_reg    <= DEAD;
                  dead_cnt_reg <= '0;
                end else begin
                  if (pending_reg) begin
                    duty_active_reg <= shadow_duty_reg;
                    pending_reg     <= 1'b0;
                  end
                  period_start_out <= 1'b1;
                end
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
          end

          DEAD: begin
            pwm_out <= 1'b0;
            if (tick_in) begin
              if (dead_cnt_reg == DEAD_LAST) begin
                dir_out          <= shadow_dir_reg;
                duty_active_reg  <= shadow_duty_reg;
                pending_reg      <= 1'b0;
                state_reg        <= RUN;
                cnt_reg          <= '0;
                dead_cnt_reg     <= '0;
                period_start_out <= 1'b1;
              end else begin
                dead_cnt_reg <= dead_cnt_reg + 8'd1;
              end
            end
          end

          default: begin
            state_reg <= IDLE;
            pwm_out   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_pwm.sv
// Directed bench for motor_pwm with PERIOD=10, DEADTIME=4.
module tb_motor_pwm;

  logic       clk_in;
  logic       reset_n_in;
  logic       tick_in;
  logic       enable_in;
  logic [3:0] duty_in;
  logic       dir_in;
  logic       cmd_valid_in;
  logic       cmd_ready_out;
  logic       pwm_out;
  logic       dir_out;
  logic       period_start_out;

  int tests;
  int fails;

  motor_pwm #(.PERIOD(10), .DEADTIME(4)) dut (
    .clk_in           (clk_in),
    .reset_n_in       (reset_n_in),
    .tick_in          (tick_in),
    .enable_in        (enable_in),
    .duty_in          (duty_in),
    .dir_in           (dir_in),
    .cmd_valid_in     (cmd_valid_in),
    .cmd_ready_out    (cmd_ready_out),
    .pwm_out          (pwm_out),
    .dir_out          (dir_out),
    .period_start_out (period_start_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset_n_in   = 1'b0;
    tick_in      = 1'b1;
    enable_in    = 1'b0;
    duty_in      = 4'd0;
    dir_in       = 1'b0;
    cmd_valid_in = 1'b0;
    step();
    step();
    tests++;
    if ({pwm_out, dir_out, period_start_out, cmd_ready_out} !== 4'b0001) begin
      fails++;
      $display("FAIL reset outputs got pwm/dir/ps/rdy=%b want 0001",
               {pwm_out, dir_out, period_start_out, cmd_ready_out});
    end
    reset_n_in = 1'b1;
    $display("[TB] test_reset done");
  endtask

  task automatic test_duty_step();
    cmd_valid_in = 1'b1;
    duty_in      = 4'd3;
    dir_in       = 1'b0;
    step();
    tests++;
    if (cmd_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL duty_step capture ready got %b want 0", cmd_ready_out);
    end
    cmd_valid_in = 1'b0;
    enable_in    = 1'b1;
    step();
    tests++;
    if ({period_start_out, pwm_out, cmd_ready_out, dir_out} !== 4'b1010) begin
      fails++;
      $display("FAIL duty_step entry got ps/pwm/rdy/dir=%b want 1010",
               {period_start_out, pwm_out, cmd_ready_out, dir_out});
    end
    for (int k = 0; k < 20; k++) begin
      step();
      tests++;
      if (pwm_out !== ((k % 10) < 3) || period_start_out !== ((k % 10) == 9)) begin
        fails++;
        $display("FAIL duty_step k=%0d got pwm=%b ps=%b want pwm=%b ps=%b",
                 k, pwm_out, period_start_out, (k % 10) < 3, (k % 10) == 9);
      end
    end
    $display("[TB] test_duty_step done");
  endtask

  // Also covers capture rejected on the same edge as a wrap load.
  task automatic test_deferred();
    for (int s = 0; s < 10; s++) begin
      if (s == 2) begin
        cmd_valid_in = 1'b1;
        duty_in      = 4'd7;
      end
      if (s == 3) duty_in = 4'd5;
      step();
      tests++;
      if (pwm_out !== (s < 3) || cmd_ready_out !== !(s >= 2 && s < 9) ||
          period_start_out !== (s == 9)) begin
        fails++;
        $display("FAIL deferred p1 s=%0d got pwm=%b rdy=%b ps=%b want pwm=%b rdy=%b ps=%b",
                 s, pwm_out, cmd_ready_out, period_start_out,
                 s < 3, !(s >= 2 && s < 9), s == 9);
      end
    end
    for (int s = 0; s < 10; s++) begin
      step();
      if (s == 0) cmd_valid_in = 1'b0;
      tests++;
      if (pwm_out !== (s < 7) || cmd_ready_out !== (s == 9) ||
          period_start_out !== (s == 9)) begin
        fails++;
        $display("FAIL deferred p2 s=%0d got pwm=%b rdy=%b ps=%b want pwm=%b rdy=%b ps=%b",
                 s, pwm_out, cmd_ready_out, period_start_out, s < 7, s == 9, s == 9);
      end
    end
    for (int s = 0; s < 10; s++) begin
      step();
      tests++;
      if (pwm_out !== (s < 5) || period_start_out !== (s == 9)) begin
        fails++;
        $display("FAIL deferred p3 s=%0d got pwm=%b ps=%b want pwm=%b ps=%b",
                 s, pwm_out, period_start_out, s < 5, s == 9);
      end
    end
    $display("[TB] test_deferred done");
  endtask

  task automatic test_reversal();
    cmd_valid_in = 1'b1;
    duty_in      = 4'd3;
    dir_in       = 1'b1;
    for (int s = 0; s < 10; s++) begin
      step();
      if (s == 0) cmd_valid_in = 1'b0;
      tests++;
      if (pwm_out !== (s < 5) || dir_out !== 1'b0 || period_start_out !== 1'b0) begin
        fails++;
        $display("FAIL reversal pre s=%0d got pwm=%b dir=%b ps=%b want pwm=%b dir=0 ps=0",
                 s, pwm_out, dir_out, period_start_out, s < 5);
      end
    end
    for (int d = 0; d < 4; d++) begin
      step();
      tests++;
      if (pwm_out !== 1'b0 || dir_out !== (d == 3) || period_start_out !== (d == 3) ||
          cmd_ready_out !== (d == 3)) begin
        fails++;
        $display("FAIL reversal dead d=%0d got pwm=%b dir=%b ps=%b rdy=%b want pwm=0 dir=%b ps=%b rdy=%b",
                 d, pwm_out, dir_out, period_start_out, cmd_ready_out, d == 3, d == 3, d == 3);
      end
    end
    for (int s = 0; s < 10; s++) begin
      step();
      tests++;
      if (pwm_out !== (s < 3) || dir_out !== 1'b1 || period_start_out !== (s == 9)) begin
        fails++;
        $display("FAIL reversal post s=%0d got pwm=%b dir=%b ps=%b want pwm=%b dir=1 ps=%b",
                 s, pwm_out, dir_out, period_start_out, s < 3, s == 9);
      end
    end
    $display("[TB] test_reversal done");
  endtask

  task automatic test_extremes();
    int cmds[3];
    int applied[3];
    int prev;
    cmds    = '{0, 10, 15};
    applied = '{0, 10, 10};
    prev    = 3;
    for (int j = 0; j < 4; j++) begin
      if (j < 3) begin
        cmd_valid_in = 1'b1;
        duty_in      = 4'(cmds[j]);
        dir_in       = 1'b1;
      end
      for (int s = 0; s < 10; s++) begin
        step();
        if (s == 0) cmd_valid_in = 1'b0;
        tests++;
        if (pwm_out !== (s < prev) || period_start_out !== (s == 9)) begin
          fails++;
          $display("FAIL extremes j=%0d s=%0d got pwm=%b ps=%b want pwm=%b ps=%b",
                   j, s, pwm_out, period_start_out, s < prev, s == 9);
        end
      end
      if (j < 3) prev = applied[j];
    end
    $display("[TB] test_extremes done");
  endtask

  task automatic test_disable_dead();
    cmd_valid_in = 1'b1;
    duty_in      = 4'd5;
    dir_in       = 1'b0;
    for (int s = 0; s < 10; s++) begin
      step();
      if (s == 0) cmd_valid_in = 1'b0;
      tests++;
      if (pwm_out !== 1'b1) begin
        fails++;
        $display("FAIL disable pre s=%0d got pwm=%b want 1", s, pwm_out);
      end
    end
    step();
    tests++;
    if (pwm_out !== 1'b0 || dir_out !== 1'b1) begin
      fails++;
      $display("FAIL disable in_dead got pwm=%b dir=%b want pwm=0 dir=1", pwm_out, dir_out);
    end
    enable_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if ({pwm_out, dir_out, period_start_out, cmd_ready_out} !== 4'b0100) begin
        fails++;
        $display("FAIL disable idle i=%0d got pwm/dir/ps/rdy=%b want 0100",
                 i, {pwm_out, dir_out, period_start_out, cmd_ready_out});
      end
    end
    enable_in = 1'b1;
    step();
    tests++;
    if ({pwm_out, dir_out, period_start_out, cmd_ready_out} !== 4'b0011) begin
      fails++;
      $display("FAIL disable reenable got pwm/dir/ps/rdy=%b want 0011",
               {pwm_out, dir_out, period_start_out, cmd_ready_out});
    end
    for (int s = 0; s < 10; s++) begin
      step();
      tests++;
      if (pwm_out !== (s < 5) || dir_out !== 1'b0 || period_start_out !== (s == 9)) begin
        fails++;
        $display("FAIL disable post s=%0d got pwm=%b dir=%b ps=%b want pwm=%b dir=0 ps=%b",
                 s, pwm_out, dir_out, period_start_out, s < 5, s == 9);
      end
    end
    $display("[TB] test_disable_dead done");
  endtask

  task automatic test_reset_mid_run();
    cmd_valid_in = 1'b1;
    duty_in      = 4'd2;
    dir_in       = 1'b1;
    step();
    tests++;
    if (cmd_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid capture ready got %b want 0", cmd_ready_out);
    end
    duty_in    = 4'd4;
    reset_n_in = 1'b0;
    step();
    tests++;
    if ({pwm_out, dir_out, period_start_out, cmd_ready_out} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_mid outputs got pwm/dir/ps/rdy=%b want 0001",
               {pwm_out, dir_out, period_start_out, cmd_ready_out});
    end
    reset_n_in   = 1'b1;
    cmd_valid_in = 1'b0;
    step();
    tests++;
    if ({pwm_out, dir_out, period_start_out, cmd_ready_out} !== 4'b0011) begin
      fails++;
      $display("FAIL reset_mid restart got pwm/dir/ps/rdy=%b want 0011",
               {pwm_out, dir_out, period_start_out, cmd_ready_out});
    end
    for (int s = 0; s < 10; s++) begin
      step();
      tests++;
      if (pwm_out !== 1'b0 || period_start_out !== (s == 9)) begin
        fails++;
        $display("FAIL reset_mid run s=%0d got pwm=%b ps=%b want pwm=0 ps=%b",
                 s, pwm_out, period_start_out, s == 9);
      end
    end
    $display("[TB] test_reset_mid_run done");
  endtask

  task automatic test_tick_gating();
    int c;
    logic tk;
    enable_in = 1'b0;
    step();
    cmd_valid_in = 1'b1;
    duty_in      = 4'd2;
    dir_in       = 1'b0;
    step();
    cmd_valid_in = 1'b0;
    tick_in      = 1'b0;
    enable_in    = 1'b1;
    step();
    tests++;
    if (period_start_out !== 1'b1 || dir_out !== 1'b0) begin
      fails++;
      $display("FAIL tick_gating entry got ps=%b dir=%b want ps=1 dir=0",
               period_start_out, dir_out);
    end
    c = 0;
    for (int i = 0; i < 30; i++) begin
      tk      = (i >= 5) && ((i % 3) != 1);
      tick_in = tk;
      step();
      tests++;
      if (pwm_out !== (c < 2) || period_start_out !== (tk && c == 9)) begin
        fails++;
        $display("FAIL tick_gating i=%0d got pwm=%b ps=%b want pwm=%b ps=%b",
                 i, pwm_out, period_start_out, c < 2, tk && c == 9);
      end
      if (tk) c = (c == 9) ? 0 : c + 1;
    end
    tick_in = 1'b1;
    $display("[TB] test_tick_gating done");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_duty_step();
    test_deferred();
    test_reversal();
    test_extremes();
    test_disable_dead();
    test_reset_mid_run();
    test_tick_gating();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/motor_pwm.md
MOTOR_PWM -- requirements
Module: motor_pwm

Interface
REQ-001 SHALL have parameter PERIOD, default 100: PWM period in tick_in pulses (2..65535).
REQ-002 SHALL have parameter DEADTIME, default 4: tick_in pulses of forced-low output on a direction reversal (1..255).
REQ-003 SHALL have port clk_in, input, 1: the only clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port reset_n_in, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port tick_in, input, 1: one-clk_in-wide enable pulse from the upstream clock-enable divider; the counter advances only on cycles where it is 1.
REQ-006 SHALL have port enable_in, input, 1: 1 = drive, 0 = coast.
REQ-007 SHALL have port duty_in, input, $clog2(PERIOD+1): requested high-time in ticks.
REQ-008 SHALL have port dir_in, input, 1: requested direction.
REQ-009 SHALL have port cmd_valid_in, input, 1: duty_in/dir_in are valid.
REQ-010 SHALL have port cmd_ready_out, output, 1: the shadow register is empty.
REQ-011 SHALL have port pwm_out, output, 1: motor PWM.
REQ-012 SHALL have port dir_out, output, 1: applied direction.
REQ-013 SHALL have port period_start_out, output, 1: one-cycle pulse at every period start.

Function
REQ-014 SHALL implement states IDLE, RUN and DEAD.
REQ-015 SHALL have a period counter cnt that runs 0..PERIOD-1 and advances only on tick_in; it wraps to 0 on the tick seen at PERIOD-1 (the wrap tick).
REQ-016 SHALL capture duty_in and dir_in into the shadow and set pending when cmd_valid_in && cmd_ready_out; cmd_ready_out = !pending.
REQ-017 SHALL clamp any captured duty above PERIOD to PERIOD.
REQ-018 On a wrap tick with pending set and shadow dir == dir_out: SHALL load duty_active from the shadow, clear pending and stay in RUN.
REQ-019 On a wrap tick with pending set and shadow dir != dir_out: SHALL enter DEAD, hold cnt at 0 and count DEADTIME ticks.
REQ-020 At the end of DEAD: SHALL update dir_out and duty_active together, clear pending and enter RUN with cnt = 0.
REQ-021 In RUN, pwm_out SHALL be registered (cnt < duty_active), lagging cnt by one clk_in cycle.
REQ-022 duty_active = 0 SHALL hold pwm_out low; duty_active = PERIOD SHALL hold pwm_out high.
REQ-023 pwm_out SHALL be 0 in IDLE and DEAD.
REQ-024 period_start_out SHALL pulse for one cycle on the clk_in cycle after a tick where cnt becomes 0 in RUN (wrap, or entry from IDLE or DEAD).
REQ-025 When enable_in goes low in any state: SHALL go to IDLE on the next clk_in, set cnt to 0, abort any DEAD without changing dir_out, and keep pending and the shadow.
REQ-026 On IDLE with enable_in=1: SHALL apply any pending command immediately (dir_out and duty_active, no dead time) and enter RUN with cnt = 0.
REQ-027 SHALL not capture a new command while pending; cmd_valid_in SHALL be held by the source until accepted.
REQ-028 When a capture and a wrap load occur in the same cycle: SHALL apply the old shadow, with the capture rejected because ready=0.
REQ-029 tick_in high for consecutive cycles SHALL be legal; each cycle counts.

Reset
REQ-030 While reset_n_in=0 at a clk_in edge: SHALL set state=IDLE, cnt=0, duty_active=0, pending=0, shadow=0, pwm_out=0, dir_out=0, period_start_out=0 and cmd_ready_out=1.
REQ-031 Reset SHALL take priority over all other inputs, including mid-DEAD and mid-handshake.

Structure
REQ-032 SHALL place the state enum type (IDLE/RUN/DEAD) in shared package motor_pkg.
REQ-033 SHALL place the default PERIOD and DEADTIME constants in motor_pkg.
REQ-034 SHALL be a single module with no sub-modules; tick_in comes from the existing clock-enable divider instantiated by the parent.

Verification
REQ-035 Duty step: PERIOD=10, tick every cycle, enable=1, command duty=3 dir=0 -> pwm_out high 3 ticks, low 7, repeating; period_start_out every 10 cycles.
REQ-036 Deferred update: duty 3->7 issued mid-period -> the current period still shows 3 high; the next period shows 7; cmd_ready_out is 0 until the wrap.
REQ-037 Reversal: dir 0->1, DEADTIME=4 -> after the wrap, pwm_out=0 for 4 ticks; dir_out toggles on exit; then the new duty applies from cnt=0.
REQ-038 Extremes: duty=0 gives constant low; duty=10 and duty=15 both give constant high with no glitch at wrap.
REQ-039 Disable mid-DEAD: enable=0 -> IDLE; pwm_out=0; dir_out unchanged; on re-enable, the new dir is applied with no dead time.
REQ-040 Reset mid-run: reset_n_in=0 for 1 cycle -> all outputs at their reset values on the next edge; cmd_ready_out=1.
